sum_pipe: RTL and testbench
===========================

Name: sum_pipe

Overview:
- Downstream consumer of the free-running `a`/`b` counter pair.
- Registers operand pairs through a 2-stage valid/ready pipeline and produces `q = a + b` with a carry-out.
- Counts delivered results.
- Replaces the bare `q <= a + b` register with a back-pressure-aware stage that feeds later sinks.

Parameters:
- WIDTH, 8, operand and sum width in bits.
- COUNT_W, 16, width of delivered-result counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair present on in_a/in_b.
- in_ready  output  1  block accepts operand pair this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- out_valid  output  1  result present on out_q/out_carry.
- out_ready  input  1  sink accepts result this cycle.
- out_q  output  WIDTH  sum, low WIDTH bits (or saturated, see Optional Feature).
- out_carry  output  1  carry-out of in_a + in_b.
- count  output  COUNT_W  number of results handed off since reset.

Behaviour:
- Reset (rst_n low, asynchronous assert, synchronous release on clk): s1_valid=0, s2_valid=0, out_valid=0, out_q=0, out_carry=0, count=0, stage-1 operand regs=0.
- Reset mid-operation: all in-flight pairs are discarded. No result appears after release until a new input is accepted.
- Stage 1 (operand register):
  - Loads in_a/in_b when in_valid && in_ready.
  - s1_valid is set on load and cleared when stage 1 advances without a new load.
- Stage 2 (sum register): loads out_q/out_carry = {carry, sum} of the stage-1 operands when s1_valid && (!s2_valid || out_ready).
- Ready rules:
  - s1_adv = s1_valid && (!s2_valid || out_ready).
  - in_ready = !s1_valid || s1_adv.
  - in_ready depends combinationally on out_ready; no other comb path from inputs to outputs.
- Latency: 2 clk edges from accepted input to out_valid=1 with no back-pressure.
- Throughput: 1 pair/cycle sustained while out_ready=1.
- Hold:
  - While out_valid && !out_ready, out_q/out_carry/out_valid stay stable.
  - Stage 1 holds its pair; in_ready=0 once both stages are full.
- Simultaneous events:
  - out handshake + s1 advance + input accept in the same cycle are all legal.
  - No bubble is inserted; ordering is preserved.
- Empty pipe: out_valid=0, in_ready=1.
- Full pipe (s1_valid && s2_valid && !out_ready): in_ready=0.
- Arithmetic:
  - Sum computed at WIDTH+1 bits; out_carry = bit WIDTH.
  - Wrap example at WIDTH=8: 200+100 -> out_q=44, out_carry=1.
- count:
  - Increments by 1 on each out_valid && out_ready.
  - Wraps from 2^COUNT_W-1 to 0.
  - Unaffected by in_valid when no handoff occurs.

Optional Feature:
- Macro: SUM_PIPE_SAT_EN.
- Defined: when the carry is 1, out_q = all ones (saturate). out_carry still reports overflow. Example: 200+100 -> out_q=255, out_carry=1.
- Undefined: out_q is the wrapped low WIDTH bits.
- Port list is identical in both builds.

Decomposition:
- Shared package sum_pkg:
  - Default WIDTH (8) and COUNT_W (16) constants.
  - Typedef for the {carry, sum} result word of WIDTH+1 bits.
- Sub-module pipe_slice: one valid/ready register slice with parameterised data width and the same clk/rst_n.
  - Instantiated twice: operand slice, then result slice.
  - Adder and saturation logic sit between the two slices in sum_pipe.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1. Expect out_valid=0, count=0, out_q=0 throughout. Deassert; first result appears exactly 2 edges after the first accepted pair.
- Streaming, out_ready=1: drive a=b=0,1,2,... one pair per cycle for 20 cycles. Expect out_q=0,2,4,... with 2-cycle latency, in_ready constantly 1, count=18 after 20 edges.
- Back-pressure:
  - Accept (3,4), then hold out_ready=0 for 5 cycles while in_valid=1 with (5,6), then (7,8).
  - Expect out_q=7 stable and in_ready=0 once both stages are full.
  - On release, expect 7, 11, 15 in order with no loss or duplication.
- Overflow at WIDTH=8: (200,100) -> out_q=44, out_carry=1; with SUM_PIPE_SAT_EN -> out_q=255, out_carry=1. (255,1) -> 0/1 wrap vs 255/1 saturate.
- Reset mid-flight: accept two pairs, pulse rst_n low between edges. Expect out_valid to drop immediately (async), no stale results after release, count=0.
- Counter wrap with COUNT_W=4: 17 handoffs -> count reads 1.

Source files
------------

// File: rtl/sum_pkg.sv
// Shared defaults and the {carry, sum} result word for the sum_pipe slice.
package sum_pkg;

  localparam int SUM_WIDTH   = 8;
  localparam int SUM_COUNT_W = 16;

  // Result word at the default width: carry-out above the WIDTH-bit sum.
  typedef struct packed {
    logic                 carry;
    logic [SUM_WIDTH-1:0] sum;
  } sum_word_t;

endpackage

// File: rtl/sum_pipe_if.sv
// Operand/result handshake bundle for sum_pipe; the slave modport is the adder side.
interface sum_pipe_if
  import sum_pkg::*;
#(
  parameter int WIDTH   = SUM_WIDTH,
  parameter int COUNT_W = SUM_COUNT_W
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_q;
  logic               out_carry;
  logic [COUNT_W-1:0] count;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_q, out_carry, count
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_q, out_carry, count
  );

endinterface

// File: rtl/pipe_slice.sv
// Single valid/ready register slice; in_ready looks through to out_ready so a full
// slice still accepts when its contents leave in the same cycle.
module pipe_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_reg;
  logic [W-1:0] data_reg;

  assign in_ready  = !valid_reg || out_ready;
  assign out_valid = valid_reg;
  assign out_data  = data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else begin
      if (in_valid && in_ready) begin
        valid_reg <= 1'b1;
        data_reg  <= in_data;
      end else if (out_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sum_pipe.sv
// Two-stage valid/ready adder: operand slice -> adder -> result slice, plus a handoff counter.
// Build with SUM_PIPE_SAT_EN defined to clamp out_q to all ones whenever the sum carries out.
module sum_pipe
  import sum_pkg::*;
#(
  parameter int WIDTH   = SUM_WIDTH,
  parameter int COUNT_W = SUM_COUNT_W
) (
  input  logic      clk,
  input  logic      rst_n,
  sum_pipe_if.slave bus
);

  localparam int OPND_W = 2 * WIDTH;
  localparam int RES_W  = WIDTH + 1;

  logic               s1_valid;
  logic               s1_ready;
  logic [OPND_W-1:0]  s1_data;
  logic [WIDTH-1:0]   s1_a;
  logic [WIDTH-1:0]   s1_b;
  logic [RES_W-1:0]   raw_sum;
  logic [WIDTH-1:0]   sum_q;
  logic [RES_W-1:0]   res_word;
  logic [RES_W-1:0]   s2_data;
  logic [COUNT_W-1:0] count_reg;

  pipe_slice #(.W(OPND_W)) u_opnd (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (bus.in_valid),
    .in_ready (bus.in_ready),
    .in_data  ({bus.in_a, bus.in_b}),
    .out_valid(s1_valid),
    .out_ready(s1_ready),
    .out_data (s1_data)
  );

  assign s1_a    = s1_data[OPND_W-1:WIDTH];
  assign s1_b    = s1_data[WIDTH-1:0];
  assign raw_sum = {1'b0, s1_a} + {1'b0, s1_b};

`ifdef SUM_PIPE_SAT_EN
  assign sum_q = raw_sum[WIDTH] ? '1 : raw_sum[WIDTH-1:0];
`else
  assign sum_q = raw_sum[WIDTH-1:0];
`endif

  // Carry always reports true overflow, even when the sum itself is clamped.
  assign res_word = {raw_sum[WIDTH], sum_q};

  pipe_slice #(.W(RES_W)) u_res (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (s1_valid),
    .in_ready (s1_ready),
    .in_data  (res_word),
    .out_valid(bus.out_valid),
    .out_ready(bus.out_ready),
    .out_data (s2_data)
  );

  assign bus.out_q     = s2_data[WIDTH-1:0];
  assign bus.out_carry = s2_data[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (bus.out_valid && bus.out_ready) begin
      count_reg <= count_reg + COUNT_W'(1);
    end
  end

  assign bus.count = count_reg;

endmodule

// File: tb/tb_sum_pipe.sv
// Randomised scoreboard bench for sum_pipe, with a COUNT_W=4 instance for counter wrap.
module tb_sum_pipe;
  import sum_pkg::*;

  localparam int W   = SUM_WIDTH;
  localparam int CW  = SUM_COUNT_W;
  localparam int CW4 = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sum_pipe_if #(.WIDTH(W), .COUNT_W(CW))  bus ();
  sum_pipe_if #(.WIDTH(W), .COUNT_W(CW4)) bus4 ();

  sum_pipe #(.WIDTH(W), .COUNT_W(CW))  dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  sum_pipe #(.WIDTH(W), .COUNT_W(CW4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  typedef struct {
    sum_word_t w;
    int        cyc;
  } exp_t;

  // Monitor-owned state
  exp_t           sb_q[$];
  int             n_checks = 0;
  int             n_fail   = 0;
  int             cyc      = 0;
  int             seen_epoch = 0;
  int             seen_cnt   = 0;
  logic [CW-1:0]  exp_count  = '0;
  logic [CW4-1:0] exp_count4 = '0;
  logic           prev_stall = 1'b0;
  logic [W-1:0]   prev_q     = '0;
  logic           prev_c     = 1'b0;

  // Stimulus-owned control, read by the monitor
  int             rst_epoch  = 0;
  logic           snap_valid = 1'b0;
  logic [CW-1:0]  snap_count = '0;
  logic           lat_exact  = 1'b0;
  logic           stream_chk = 1'b0;
  logic           hold_chk   = 1'b0;
  logic [W-1:0]   hold_q     = '0;
  int             cnt_req    = 0;
  int             cnt_dut    = 0;
  int             cnt_val    = 0;
  logic           final_chk  = 1'b0;

  // Reference: plain integer addition, split into carry and low bits.
  function automatic sum_word_t model(int a, int b);
    sum_word_t r;
    int s;
    s       = a + b;
    r.carry = (s >= (1 << W));
    r.sum   = W'(s % (1 << W));
`ifdef SUM_PIPE_SAT_EN
    if (r.carry) r.sum = '1;
`endif
    return r;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_epoch != seen_epoch) begin
      seen_epoch = rst_epoch;
      sb_q.delete();
      exp_count  = '0;
      exp_count4 = '0;
      prev_stall = 1'b0;
      check("async_rst_out_valid", 32'(snap_valid), 32'd0);
      check("async_rst_count", 32'(snap_count), 32'd0);
    end
    if (!rst_n) begin
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_q", 32'(bus.out_q), 32'd0);
      check("rst_out_carry", 32'(bus.out_carry), 32'd0);
      check("rst_count", 32'(bus.count), 32'd0);
      prev_stall = 1'b0;
    end else begin
      check("count", 32'(bus.count), 32'(exp_count));
      check("count4", 32'(bus4.count), 32'(exp_count4));
      if (prev_stall) begin
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_q", 32'(bus.out_q), 32'(prev_q));
        check("hold_carry", 32'(bus.out_carry), 32'(prev_c));
      end
      if (stream_chk) check("stream_in_ready", 32'(bus.in_ready), 32'd1);
      if (hold_chk) begin
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        check("full_out_q", 32'(bus.out_q), 32'(hold_q));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output at %0t: got out_q=%0d with no pending pair", $time, bus.out_q);
        end else begin
          e = sb_q.pop_front();
          check("out_q", 32'(bus.out_q), 32'(e.w.sum));
          check("out_carry", 32'(bus.out_carry), 32'(e.w.carry));
          if (lat_exact) check("latency", 32'(cyc - e.cyc), 32'd2);
        end
        exp_count = exp_count + 1'b1;
      end
      if (bus4.out_valid && bus4.out_ready) exp_count4 = exp_count4 + 1'b1;
      if (bus.in_valid && bus.in_ready)
        sb_q.push_back('{model(int'(bus.in_a), int'(bus.in_b)), cyc});
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_q     = bus.out_q;
      prev_c     = bus.out_carry;
      if (cnt_req != seen_cnt) begin
        seen_cnt = cnt_req;
        if (cnt_dut == 0) check("count_total", 32'(bus.count), 32'(cnt_val));
        else              check("count4_wrap", 32'(bus4.count), 32'(cnt_val));
      end
      if (final_chk) check("drain_empty", 32'(sb_q.size()), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int a, int b);
    bus.in_valid = 1'b1;
    bus.in_a     = W'(a);
    bus.in_b     = W'(b);
  endtask

  // Reset pulse placed strictly between clock edges.
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    snap_valid = bus.out_valid;
    snap_count = bus.count;
    rst_epoch++;
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    bus.in_valid  = 1'b1;
    bus.in_a      = W'(1);
    bus.in_b      = W'(2);
    bus.out_ready = 1'b1;
    bus4.in_valid  = 1'b0;
    bus4.in_a      = '0;
    bus4.in_b      = '0;
    bus4.out_ready = 1'b1;
    lat_exact = 1'b1;

    // Power-on reset held with in_valid high, then release between edges
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();

    // Streaming a=b=i, one pair per cycle
    do_reset();
    stream_chk = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(i, i);
      tick();
    end
    stream_chk   = 1'b0;
    bus.in_valid = 1'b0;
    cnt_dut = 0;
    cnt_val = 18;
    cnt_req++;
    repeat (4) tick();
    lat_exact = 1'b0;

    // Back-pressure: 7 parked in stage 2, (5,6) in stage 1, (7,8) waiting
    do_reset();
    drive(3, 4);
    tick();
    bus.out_ready = 1'b0;
    drive(5, 6);
    tick();
    drive(7, 8);
    hold_q   = W'(7);
    hold_chk = 1'b1;
    repeat (4) tick();
    hold_chk      = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();

    // Mid-flight reset with two pairs in the pipe
    bus.out_ready = 1'b0;
    drive(9, 9);
    tick();
    drive(10, 10);
    tick();
    bus.in_valid = 1'b0;
    do_reset();
    bus.out_ready = 1'b1;
    repeat (4) tick();

    // Overflow corners, then random traffic with random back-pressure
    lat_exact = 1'b1;
    drive(200, 100); tick();
    drive(255, 1);   tick();
    drive(255, 255); tick();
    drive(0, 0);     tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    lat_exact = 1'b0;
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_a      = W'($urandom_range(0, 255));
      bus.in_b      = W'($urandom_range(0, 255));
      bus.out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) tick();

    // Counter wrap on the COUNT_W=4 instance: 17 handoffs
    do_reset();
    for (int i = 0; i < 17; i++) begin
      bus4.in_valid = 1'b1;
      bus4.in_a     = W'(i);
      bus4.in_b     = W'(1);
      tick();
    end
    bus4.in_valid = 1'b0;
    repeat (2) tick();
    cnt_dut = 1;
    cnt_val = 1;
    cnt_req++;
    repeat (3) tick();

    final_chk = 1'b1;
    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
